// File: rtl/axis_arb_pkg.sv
// Shared types and constants for the AXI-Stream packet arbiter.
// Also used by the width-converter integration.
package axis_arb_pkg;

  typedef enum logic {
    ARB_IDLE,
    ARB_PASS
  } arb_state_e;

  localparam int AXIS_MAX_PKT_BEATS = 256;

  function automatic int src_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_grant_picker.sv
// Combinational round-robin picker: first request at or after
// last_grant+1, wrapping modulo NUM_SRC.
module rr_grant_picker
  import axis_arb_pkg::*;
#(
  parameter int NUM_SRC = 4,
  localparam int SRC_W = src_w(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [SRC_W-1:0]   last_grant,
  output logic [SRC_W-1:0]   grant,
  output logic               any_req
);

  logic [SRC_W-1:0] idx;

  always_comb begin
    grant   = last_grant;
    any_req = 1'b0;
    idx     = '0;
    for (int i = 1; i <= NUM_SRC; i++) begin
      idx = SRC_W'((int'(last_grant) + i) % NUM_SRC);
      if (!any_req && req[idx]) begin
        any_req = 1'b1;
        grant   = idx;
      end
    end
  end

endmodule

// File: rtl/axis_packet_rr_arbiter.sv
// Packet-granular round-robin mux of NUM_SRC AXI-Stream sources
// onto one stream; grant held from first beat to TLAST.
module axis_packet_rr_arbiter
  import axis_arb_pkg::*;
#(
  parameter int NUM_SRC            = 4,
  parameter int C_AXIS_TDATA_WIDTH = 64,
  parameter int MAX_PKT_BEATS      = AXIS_MAX_PKT_BEATS,
  localparam int SRC_W = src_w(NUM_SRC)
) (
  input  logic                                  aclk,
  input  logic                                  areset,
  input  logic                                  arb_enable,
  input  logic [NUM_SRC-1:0]                    src_mask,
  input  logic [NUM_SRC*C_AXIS_TDATA_WIDTH-1:0] S_AXIS_TDATA,
  input  logic [NUM_SRC-1:0]                    S_AXIS_TVALID,
  input  logic [NUM_SRC-1:0]                    S_AXIS_TLAST,
  output logic [NUM_SRC-1:0]                    S_AXIS_TREADY,
  output logic [C_AXIS_TDATA_WIDTH-1:0]         M_AXIS_TDATA,
  output logic                                  M_AXIS_TVALID,
  output logic                                  M_AXIS_TLAST,
  output logic [SRC_W-1:0]                      M_AXIS_TUSER,
  input  logic                                  M_AXIS_TREADY,
  output logic [31:0]                           pkt_count,
  output logic                                  err_overlong
);

  localparam int BCW =
    (MAX_PKT_BEATS > 1) ? $clog2(MAX_PKT_BEATS) : 1;
  localparam logic [BCW-1:0] LAST_BEAT =
    BCW'(MAX_PKT_BEATS - 1);

  arb_state_e       state_q, state_d;
  logic [SRC_W-1:0] grant_q, last_grant_q, pick;
  logic [BCW-1:0]   beat_cnt_q;
  logic             any_req, hs, done, forced;
  logic             sel_valid, sel_last;

  logic [C_AXIS_TDATA_WIDTH-1:0] src_data [NUM_SRC];

  for (genvar k = 0; k < NUM_SRC; k++) begin : g_unpack
    assign src_data[k] =
      S_AXIS_TDATA[k*C_AXIS_TDATA_WIDTH +: C_AXIS_TDATA_WIDTH];
  end

  rr_grant_picker #(
    .NUM_SRC(NUM_SRC)
  ) u_pick (
    .req        (S_AXIS_TVALID & src_mask),
    .last_grant (last_grant_q),
    .grant      (pick),
    .any_req    (any_req)
  );

  assign sel_valid = S_AXIS_TVALID[grant_q];
  assign sel_last  = S_AXIS_TLAST[grant_q];
  assign forced    = (beat_cnt_q == LAST_BEAT);

  always_comb begin
    state_d       = state_q;
    M_AXIS_TDATA  = '0;
    M_AXIS_TVALID = 1'b0;
    M_AXIS_TLAST  = 1'b0;
    M_AXIS_TUSER  = '0;
    S_AXIS_TREADY = '0;
    err_overlong  = 1'b0;
    hs            = 1'b0;
    done          = 1'b0;
    unique case (state_q)
      ARB_IDLE: begin
        if (arb_enable && any_req) state_d = ARB_PASS;
      end
      ARB_PASS: begin
        M_AXIS_TVALID          = sel_valid;
        M_AXIS_TDATA           = src_data[grant_q];
        M_AXIS_TUSER           = grant_q;
        M_AXIS_TLAST           = sel_last | forced;
        S_AXIS_TREADY[grant_q] = M_AXIS_TREADY;
        hs   = sel_valid & M_AXIS_TREADY;
        done = hs & M_AXIS_TLAST;
        err_overlong = done & forced & ~sel_last;
        if (done) state_d = ARB_IDLE;
      end
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q      <= ARB_IDLE;
      grant_q      <= '0;
      last_grant_q <= SRC_W'(NUM_SRC - 1);
      beat_cnt_q   <= '0;
      pkt_count    <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ARB_IDLE && state_d == ARB_PASS) begin
        grant_q    <= pick;
        beat_cnt_q <= '0;
      end else if (hs && !done) begin
        beat_cnt_q <= beat_cnt_q + 1'b1;
      end
      if (done) begin
        last_grant_q <= grant_q;
        pkt_count    <= pkt_count + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_axis_packet_rr_arbiter.sv
// Directed bench for axis_packet_rr_arbiter; a second instance
// with MAX_PKT_BEATS=4 covers the overlong guard.
module tb_axis_packet_rr_arbiter;

  logic         aclk = 1'b0;
  logic         areset = 1'b1;
  logic         arb_enable = 1'b1;
  logic [3:0]   src_mask = 4'hf;
  logic [255:0] s_tdata;
  logic [3:0]   s_tvalid, s_tlast;
  logic         m_tready = 1'b1;
  logic         sel4 = 1'b0;

  logic [3:0]  a_srdy, b_srdy, s_tready;
  logic [63:0] a_data, b_data, m_tdata;
  logic        a_val, b_val, m_tvalid;
  logic        a_last, b_last, m_tlast;
  logic [1:0]  a_user, b_user, m_tuser;
  logic [31:0] a_cnt, b_cnt, pkt_cnt;
  logic        a_err, b_err, err;

  int tests = 0;
  int failed = 0;
  int bi [4];
  int len [4];
  logic [3:0] vmask = 4'h0;
  logic [3:0] oneshot = 4'h0;

  always #5 aclk = ~aclk;

  axis_packet_rr_arbiter dut (
    .aclk(aclk), .areset(areset),
    .arb_enable(arb_enable), .src_mask(src_mask),
    .S_AXIS_TDATA(s_tdata), .S_AXIS_TVALID(s_tvalid),
    .S_AXIS_TLAST(s_tlast), .S_AXIS_TREADY(a_srdy),
    .M_AXIS_TDATA(a_data), .M_AXIS_TVALID(a_val),
    .M_AXIS_TLAST(a_last), .M_AXIS_TUSER(a_user),
    .M_AXIS_TREADY(m_tready), .pkt_count(a_cnt),
    .err_overlong(a_err)
  );

  axis_packet_rr_arbiter #(.MAX_PKT_BEATS(4)) dut4 (
    .aclk(aclk), .areset(areset),
    .arb_enable(arb_enable), .src_mask(src_mask),
    .S_AXIS_TDATA(s_tdata), .S_AXIS_TVALID(s_tvalid),
    .S_AXIS_TLAST(s_tlast), .S_AXIS_TREADY(b_srdy),
    .M_AXIS_TDATA(b_data), .M_AXIS_TVALID(b_val),
    .M_AXIS_TLAST(b_last), .M_AXIS_TUSER(b_user),
    .M_AXIS_TREADY(m_tready), .pkt_count(b_cnt),
    .err_overlong(b_err)
  );

  assign s_tready = sel4 ? b_srdy : a_srdy;
  assign m_tdata  = sel4 ? b_data : a_data;
  assign m_tvalid = sel4 ? b_val  : a_val;
  assign m_tlast  = sel4 ? b_last : a_last;
  assign m_tuser  = sel4 ? b_user : a_user;
  assign pkt_cnt  = sel4 ? b_cnt  : a_cnt;
  assign err      = sel4 ? b_err  : a_err;

  function automatic logic [63:0] dat(input int k, input int b);
    return {8'(k), 48'h0, 8'(b)};
  endfunction

  task automatic apply();
    for (int k = 0; k < 4; k++) begin
      s_tdata[k*64 +: 64] = dat(k, bi[k]);
      s_tvalid[k] = vmask[k];
      s_tlast[k]  = (bi[k] == len[k] - 1);
    end
  endtask

  task automatic tick();
    logic [3:0] hs;
    hs = s_tready & s_tvalid;
    @(posedge aclk);
    #1;
    for (int k = 0; k < 4; k++) begin
      if (hs[k]) begin
        if (bi[k] == len[k] - 1) begin
          bi[k] = 0;
          if (oneshot[k]) vmask[k] = 1'b0;
        end else begin
          bi[k]++;
        end
      end
    end
    apply();
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".vld"}, 64'(m_tvalid), 64'd0);
    chk({tag, ".srdy"}, 64'(s_tready), 64'd0);
    chk({tag, ".data"}, m_tdata, 64'd0);
    chk({tag, ".user"}, 64'(m_tuser), 64'd0);
    chk({tag, ".last"}, 64'(m_tlast), 64'd0);
  endtask

  task automatic chk_beat(input string tag, input int g,
                          input int b, input logic last);
    chk({tag, ".vld"}, 64'(m_tvalid), 64'd1);
    chk({tag, ".user"}, 64'(m_tuser), 64'(g));
    chk({tag, ".data"}, m_tdata, dat(g, b));
    chk({tag, ".last"}, 64'(m_tlast), 64'(last));
    chk({tag, ".srdy"}, 64'(s_tready),
        m_tready ? 64'(4'b1 << g) : 64'd0);
  endtask

  task automatic do_reset();
    vmask = 4'h0;
    oneshot = 4'h0;
    for (int k = 0; k < 4; k++) begin
      bi[k] = 0;
      len[k] = 1;
    end
    apply();
    areset = 1'b1;
    repeat (2) @(posedge aclk);
    #1;
    areset = 1'b0;
    #1;
  endtask

  int tr [6] = '{1, 0, 1, 0, 1, 1};
  int eb [6] = '{0, 1, 1, 2, 2, 3};

  initial begin
    // reset state
    do_reset();
    chk_idle("rst");
    chk("rst.cnt", 64'(pkt_cnt), 64'd0);
    chk("rst.err", 64'(err), 64'd0);

    // single 8-beat packet from source 0
    len[0] = 8;
    oneshot[0] = 1'b1;
    vmask = 4'b0001;
    apply();
    #1;
    chk_idle("s1.arb");
    tick();
    for (int b = 0; b < 8; b++) begin
      chk_beat("s1", 0, b, b == 7);
      chk("s1.err", 64'(err), 64'd0);
      tick();
    end
    chk_idle("s1.end");
    chk("s1.cnt", 64'(pkt_cnt), 64'd1);

    // fairness: four sources, continuous 2-beat packets
    do_reset();
    for (int k = 0; k < 4; k++) len[k] = 2;
    vmask = 4'hf;
    apply();
    #1;
    for (int c = 0; c < 40; c++) begin
      if (c % 3 == 0) chk_idle("rr.gap");
      else chk_beat("rr", (c / 3) % 4, (c % 3) - 1, (c % 3) == 2);
      tick();
    end
    chk("rr.cnt", 64'(pkt_cnt), 64'd13);

    // backpressure mid-packet
    do_reset();
    len[1] = 4;
    oneshot[1] = 1'b1;
    vmask = 4'b0010;
    apply();
    #1;
    tick();
    for (int i = 0; i < 6; i++) begin
      m_tready = tr[i][0];
      #1;
      chk_beat("bp", 1, eb[i], eb[i] == 3);
      tick();
    end
    chk_idle("bp.end");
    chk("bp.cnt", 64'(pkt_cnt), 64'd1);

    // overlong guard on the MAX_PKT_BEATS=4 instance
    sel4 = 1'b1;
    do_reset();
    len[2] = 6;
    oneshot[2] = 1'b1;
    vmask = 4'b0100;
    apply();
    #1;
    tick();
    for (int b = 0; b < 4; b++) begin
      chk_beat("ol", 2, b, b == 3);
      chk("ol.err", 64'(err), 64'(b == 3));
      tick();
    end
    chk_idle("ol.gap");
    chk("ol.cnt1", 64'(pkt_cnt), 64'd1);
    tick();
    for (int b = 4; b < 6; b++) begin
      chk_beat("ol2", 2, b, b == 5);
      chk("ol2.err", 64'(err), 64'd0);
      tick();
    end
    chk_idle("ol.end");
    chk("ol.cnt2", 64'(pkt_cnt), 64'd2);
    sel4 = 1'b0;

    // masking: only sources 1 and 3, single-beat packets
    do_reset();
    src_mask = 4'b1010;
    vmask = 4'hf;
    apply();
    #1;
    for (int c = 0; c < 8; c++) begin
      if (c % 2 == 0) chk_idle("mk.gap");
      else chk_beat("mk", ((c / 2) % 2 == 1) ? 3 : 1, 0, 1'b1);
      tick();
    end
    chk("mk.cnt", 64'(pkt_cnt), 64'd4);
    src_mask = 4'hf;

    // arb_enable dropped mid-packet
    do_reset();
    len[0] = 3;
    len[1] = 3;
    vmask = 4'b0011;
    apply();
    #1;
    tick();
    chk_beat("en", 0, 0, 1'b0);
    arb_enable = 1'b0;
    tick();
    chk_beat("en", 0, 1, 1'b0);
    tick();
    chk_beat("en", 0, 2, 1'b1);
    tick();
    chk_idle("en.off1");
    tick();
    chk_idle("en.off2");
    chk("en.cnt", 64'(pkt_cnt), 64'd1);
    arb_enable = 1'b1;
    #1;
    tick();
    chk_beat("en.on", 1, 0, 1'b0);
    tick();
    tick();
    tick();
    chk("en.cnt2", 64'(pkt_cnt), 64'd2);

    // reset mid-packet at beat 3 (last_grant is 1 here)
    len[2] = 8;
    oneshot[2] = 1'b1;
    vmask = 4'b0100;
    apply();
    #1;
    tick();
    for (int b = 0; b < 3; b++) tick();
    chk_beat("mr", 2, 3, 1'b0);
    areset = 1'b1;
    tick();
    areset = 1'b0;
    #1;
    chk_idle("mr.rst");
    chk("mr.cnt", 64'(pkt_cnt), 64'd0);
    len[0] = 2;
    bi[0] = 0;
    vmask = 4'b0101;
    apply();
    #1;
    tick();
    chk_beat("mr.first", 0, 0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/axis_packet_rr_arbiter.md
# axis_packet_rr_arbiter

Packet-granular round-robin arbiter that shares the single 64-bit input of the 64-to-512 AXI-Stream width converter between NUM_SRC independent 64-bit DMA streams. A grant is held from the first beat to the TLAST beat of one packet, so 512-bit collection never mixes sources. The winning source index travels on M_AXIS_TUSER. The block sits directly upstream of the width converter, between the DMA channels and the converter's S_AXIS port.

## Interface
- NUM_SRC, 4, number of requesting source streams (2..8)
- C_AXIS_TDATA_WIDTH, 64, data width on every port
- MAX_PKT_BEATS, 256, overlong-packet guard: maximum beats per packet before a forced TLAST
- SRC_W, $clog2(NUM_SRC), source index width (derived, not overridable)

- aclk  in  1  clock; everything is synchronous to its rising edge
- areset  in  1  synchronous, active-high reset
- arb_enable  in  1  when 0, no new grant is issued; a packet already in flight completes
- src_mask  in  NUM_SRC  per-source request enable; a bit at 1 allows that source to be granted
- S_AXIS_TDATA  in  NUM_SRC*C_AXIS_TDATA_WIDTH  packed source data; source k occupies bits [k*64 +: 64]
- S_AXIS_TVALID  in  NUM_SRC  per-source valid
- S_AXIS_TLAST  in  NUM_SRC  per-source last
- S_AXIS_TREADY  out  NUM_SRC  per-source ready
- M_AXIS_TDATA  out  C_AXIS_TDATA_WIDTH  data to the width converter
- M_AXIS_TVALID  out  1  output valid
- M_AXIS_TLAST  out  1  output last: the source TLAST, or a forced TLAST from the guard
- M_AXIS_TUSER  out  SRC_W  index of the granted source
- M_AXIS_TREADY  in  1  ready from the width converter
- pkt_count  out  32  packets completed since reset; wraps at 2^32
- err_overlong  out  1  one-cycle pulse when a forced TLAST is emitted

## Operation
- FSM states:
  - IDLE: no grant; all S_AXIS_TREADY=0; M_AXIS_TVALID=0.
  - PASS: grant g is held.
- IDLE→PASS when arb_enable=1 and req = S_AXIS_TVALID & src_mask is nonzero.
  - g = first set bit of req, searching upward from (last_grant+1) mod NUM_SRC.
  - g is registered; the beat counter is cleared.
- PASS signal mapping:
  - M_AXIS_TVALID = S_AXIS_TVALID[g]
  - M_AXIS_TDATA = source g data
  - M_AXIS_TUSER = g
  - S_AXIS_TREADY[g] = M_AXIS_TREADY; all other readys are 0.
  - The pass-through is combinational; there is no data register.
- Beat accounting: beat_cnt increments on every output handshake (M_AXIS_TVALID & M_AXIS_TREADY).
- Forced TLAST: M_AXIS_TLAST = S_AXIS_TLAST[g] | (beat_cnt == MAX_PKT_BEATS-1).
- PASS→IDLE on an output handshake with M_AXIS_TLAST=1. On that cycle:
  - last_grant is set to g.
  - pkt_count increments.
  - err_overlong pulses if the TLAST was forced and S_AXIS_TLAST[g]=0.
- The remaining beats of a truncated packet arbitrate again as a new packet.
- Changes to src_mask or arb_enable in PASS have no effect until return to IDLE.
- Source S_AXIS_TVALID dropping mid-packet holds the grant; M_AXIS_TVALID follows the source and the block keeps waiting.
- Widths:
  - beat_cnt is $clog2(MAX_PKT_BEATS) bits and never wraps; it is cleared on each grant.
  - last_grant is SRC_W bits.

## Timing
- Reset values: state=IDLE, last_grant=NUM_SRC-1 (source 0 wins first), beat_cnt=0, pkt_count=0, err_overlong=0, M_AXIS_TVALID=0, S_AXIS_TREADY=0. M_AXIS_TDATA, M_AXIS_TUSER and M_AXIS_TLAST read 0 in IDLE.
- Arbitration latency: request visible in cycle N → first output beat possible in cycle N+1.
- Inter-packet gap: exactly one idle cycle after each TLAST handshake, including back-to-back packets from the same source.
- Throughput inside a packet: one beat per cycle while source valid and sink ready are both high.
- AXI-Stream rule: once M_AXIS_TVALID=1, data, last and user stay stable until the handshake. A source-valid drop is the only permitted deassertion.
- Reset asserted mid-packet: the next cycle is IDLE with all readys 0. The source packet is abandoned; the downstream converter is reset by the same areset.
- A single-beat packet (TLAST on beat 0) completes in PASS in one cycle.

## Structure
- Shared package axis_arb_pkg holds:
  - the state enum (ARB_IDLE, ARB_PASS)
  - the SRC_W helper function
  - the default MAX_PKT_BEATS constant shared with the converter integration.
- Sub-module rr_grant_picker: purely combinational. Inputs are req[NUM_SRC] and last_grant; outputs are grant index and any_req. It is reused by future DMA-channel schedulers.

## Test plan
- Single source: src 0 sends 8 beats 0x..00–0x..07 with TLAST on beat 7.
  - Expect 8 output beats in order, TUSER=0, TLAST on beat 7, pkt_count=1.
  - The converter downstream emits one 512-bit word.
- Fairness: all 4 sources hold 2-beat packets continuously for 40 cycles.
  - Expect grant order 0,1,2,3,0,… with one idle cycle between packets.
  - pkt_count ends at 13–14.
- Backpressure: M_AXIS_TREADY toggles 1,0,1,0 mid-packet.
  - Only S_AXIS_TREADY[g] mirrors it; output data and TUSER stay stable while ready is 0.
- Overlong: MAX_PKT_BEATS=4, source 2 sends 6 beats with TLAST only on beat 5.
  - Expect forced TLAST on beat 3 and an err_overlong pulse.
  - Beats 4–5 are regranted as a second packet; pkt_count=2.
- Masking and enable:
  - src_mask=4'b1010 with all sources valid → only grants 1 and 3.
  - arb_enable dropped mid-packet → that packet completes, then IDLE holds.
- Reset mid-packet at beat 3 → next cycle all readys 0, TVALID 0, pkt_count 0, source 0 wins first.
